pwm_timer_unit: RTL and testbench

PWM_TIMER_UNIT -- requirements
Module: pwm_timer_unit

---
 rtl/pwm_timer_pkg.sv | 50 +++++
 rtl/pwm_timer_unit_tick_gen.sv | 33 +++
 rtl/pwm_timer_unit.sv | 182 ++++++++++++++++++
 tb/tb_pwm_timer_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM timer: register map, CTRL bit layout,
// identification value and the timer state encoding.
package pwm_timer_pkg;

    // Width of one config/status register
    localparam int REG_W = 8;

    // Config register indices
    localparam int CFG_CTRL      = 0;
    localparam int CFG_PRESC     = 1;
    localparam int CFG_PERIOD_LO = 2;
    localparam int CFG_PERIOD_HI = 3;
    localparam int CFG_DUTY_LO   = 4;
    localparam int CFG_DUTY_HI   = 5;
    localparam int CFG_USED      = 6;

    // Status register indices
    localparam int ST_CNT_LO   = 0;
    localparam int ST_CNT_HI   = 1;
    localparam int ST_FLAGS    = 2;
    localparam int ST_WRAP_CNT = 3;
    localparam int ST_ID       = 4;

    // CTRL register bit positions
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_ONE_SHOT = 1;
    localparam int CTRL_INVERT   = 2;
    localparam int CTRL_CLEAR    = 3;
    localparam int CTRL_IRQ_EN   = 4;

    // Fixed identification value readable in status register 4
    localparam logic [REG_W-1:0] ID_VALUE = 8'hA5;

    // Saturation limit of the wrap counter
    localparam logic [REG_W-1:0] WRAP_CNT_MAX = 8'hFF;

    // Timer operating states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    // Assemble a 16-bit value from a low/high register pair
    function automatic logic [15:0] join16(input logic [REG_W-1:0] lo,
                                           input logic [REG_W-1:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/pwm_timer_unit_tick_gen.sv
// Prescaler: produces a one-cycle tick every (presc+1) enabled cycles while
// the timer is running; held at zero whenever the timer is not running.
module tick_gen
    import pwm_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             run,
    input  logic [REG_W-1:0] presc,
    output logic             tick
);

    logic [REG_W-1:0] presc_cnt;

    assign tick = ena && run && (presc_cnt == presc);

    // Prescale counter: restarts at zero outside RUN and after every tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (ena) begin
            if (!run) begin
                presc_cnt <= '0;
            end else if (presc_cnt == presc) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_timer_unit.sv
// PWM timer with a flat config/status register bank. Period and duty are
// captured into shadow registers at start and at every wrap, so register
// writes never disturb a period already in progress.
module pwm_timer_unit #(
    parameter int REG_WIDTH  = 8,
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            pwm_out,
    output logic                            irq
);

    import pwm_timer_pkg::*;

    // Decoded configuration
    logic [REG_WIDTH-1:0] ctrl;
    logic [REG_WIDTH-1:0] presc;
    logic [15:0]          cfg_period;
    logic [15:0]          cfg_duty;
    logic                 cfg_enable;
    logic                 cfg_one_shot;
    logic                 cfg_invert;
    logic                 cfg_clear;
    logic                 cfg_irq_en;

    // Timer state
    timer_state_e         state;
    timer_state_e         next_state;
    logic [15:0]          counter;
    logic [15:0]          shadow_period;
    logic [15:0]          shadow_duty;
    logic                 wrap_sticky;
    logic [REG_WIDTH-1:0] wrap_cnt;

    // Derived controls
    logic                 running;
    logic                 done;
    logic                 tick;
    logic                 wrap;
    logic                 start;
    logic                 raw;
    logic                 unused_cfg_bits;

    assign ctrl       = config_regs[CFG_CTRL*REG_WIDTH +: REG_WIDTH];
    assign presc      = config_regs[CFG_PRESC*REG_WIDTH +: REG_WIDTH];
    assign cfg_period = join16(config_regs[CFG_PERIOD_LO*REG_WIDTH +: REG_WIDTH],
                               config_regs[CFG_PERIOD_HI*REG_WIDTH +: REG_WIDTH]);
    assign cfg_duty   = join16(config_regs[CFG_DUTY_LO*REG_WIDTH +: REG_WIDTH],
                               config_regs[CFG_DUTY_HI*REG_WIDTH +: REG_WIDTH]);

    assign cfg_enable   = ctrl[CTRL_ENABLE];
    assign cfg_one_shot = ctrl[CTRL_ONE_SHOT];
    assign cfg_invert   = ctrl[CTRL_INVERT];
    assign cfg_clear    = ctrl[CTRL_CLEAR];
    assign cfg_irq_en   = ctrl[CTRL_IRQ_EN];

    // Registers 6 and 7 and the upper CTRL bits carry no function
    assign unused_cfg_bits = ^{config_regs[NUM_CFG*REG_WIDTH-1:CFG_USED*REG_WIDTH],
                               ctrl[REG_WIDTH-1:CTRL_IRQ_EN+1]};

    assign running = (state == RUN);
    assign done    = (state == DONE);
    assign start   = ena && (state == IDLE) && cfg_enable;
    assign wrap    = tick && (counter == shadow_period);
    assign raw     = running && (counter < shadow_duty);
    assign irq     = wrap_sticky && cfg_irq_en;

    tick_gen u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .run   (running),
        .presc (presc),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    // Next-state logic: start on enable, stop on disable, finish on one-shot wrap
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cfg_enable) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    next_state = IDLE;
                end else if (wrap && cfg_one_shot) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!cfg_enable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shadow period/duty: captured at start and refreshed only at wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_period <= '0;
            shadow_duty   <= '0;
        end else if (start || (ena && wrap)) begin
            shadow_period <= cfg_period;
            shadow_duty   <= cfg_duty;
        end
    end

    // Period counter: advances on tick, zero whenever not actively running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (ena) begin
            if (!running || !cfg_enable) begin
                counter <= '0;
            end else if (wrap) begin
                counter <= '0;
            end else if (tick) begin
                counter <= counter + 16'd1;
            end
        end
    end

    // Wrap flags: clear has priority over a coincident wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_sticky <= 1'b0;
            wrap_cnt    <= '0;
        end else if (ena) begin
            if (cfg_clear) begin
                wrap_sticky <= 1'b0;
                wrap_cnt    <= '0;
            end else if (wrap) begin
                wrap_sticky <= 1'b1;
                if (wrap_cnt != WRAP_CNT_MAX) begin
                    wrap_cnt <= wrap_cnt + 1'b1;
                end
            end
        end
    end

    // Registered PWM output with optional polarity inversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else if (ena) begin
            pwm_out <= raw ^ cfg_invert;
        end
    end

    // Status bank assembly
    always_comb begin
        status_regs = '0;
        status_regs[ST_CNT_LO*REG_WIDTH +: REG_WIDTH]   = counter[7:0];
        status_regs[ST_CNT_HI*REG_WIDTH +: REG_WIDTH]   = counter[15:8];
        status_regs[ST_FLAGS*REG_WIDTH +: REG_WIDTH]    = {4'b0000, pwm_out, done,
                                                           wrap_sticky, running};
        status_regs[ST_WRAP_CNT*REG_WIDTH +: REG_WIDTH] = wrap_cnt;
        status_regs[ST_ID*REG_WIDTH +: REG_WIDTH]       = ID_VALUE;
    end

endmodule

// File: tb/tb_pwm_timer_unit.sv
// Self-checking bench for pwm_timer_unit: a cycle model predicts outputs,
// predictions are queued before each clock edge and compared after it,
// plus directed checks of the characteristic waveforms.
module tb_pwm_timer_unit;

    localparam logic [7:0] C_EN  = 8'h01;
    localparam logic [7:0] C_ONE = 8'h02;
    localparam logic [7:0] C_INV = 8'h04;
    localparam logic [7:0] C_CLR = 8'h08;
    localparam logic [7:0] C_IRQ = 8'h10;
    localparam logic [63:0] RESET_STATUS = 64'h0000_00A5_0000_0000;

    typedef struct packed {
        logic        pwm;
        logic        irq;
        logic [63:0] st;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [7:0]  ctrl;
    logic [7:0]  presc;
    logic [15:0] period;
    logic [15:0] duty;
    logic [63:0] config_regs;
    logic [63:0] status_regs;
    logic        pwm_out;
    logic        irq;

    int checks_total;
    int checks_passed;
    exp_t sb_q[$];

    // Reference model state (0 idle, 1 run, 2 done)
    int          m_state;
    logic [15:0] m_cnt;
    logic [15:0] m_per;
    logic [15:0] m_duty;
    logic [7:0]  m_psc;
    logic [7:0]  m_wcnt;
    logic        m_sticky;
    logic        m_pwm;

    assign config_regs = {16'hC35A, duty, period, presc, ctrl};

    pwm_timer_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .pwm_out     (pwm_out),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_state  = 0;
        m_cnt    = '0;
        m_per    = '0;
        m_duty   = '0;
        m_psc    = '0;
        m_wcnt   = '0;
        m_sticky = 1'b0;
        m_pwm    = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now applied
    task automatic modelClock();
        logic run_now;
        logic tk;
        logic wr;
        if (rst) begin
            modelReset();
        end else if (ena) begin
            run_now = (m_state == 1);
            tk = run_now && (m_psc == presc);
            wr = tk && (m_cnt == m_per);
            m_pwm = (run_now && (m_cnt < m_duty)) ^ ctrl[2];
            if (ctrl[3]) begin
                m_sticky = 1'b0;
                m_wcnt   = 8'd0;
            end else if (wr) begin
                m_sticky = 1'b1;
                if (m_wcnt != 8'd255) m_wcnt = m_wcnt + 8'd1;
            end
            case (m_state)
                0: begin
                    m_cnt = '0;
                    m_psc = '0;
                    if (ctrl[0]) begin
                        m_state = 1;
                        m_per   = period;
                        m_duty  = duty;
                    end
                end
                1: begin
                    m_psc = tk ? 8'd0 : m_psc + 8'd1;
                    if (wr) begin
                        m_cnt  = '0;
                        m_per  = period;
                        m_duty = duty;
                    end else if (tk) begin
                        m_cnt = m_cnt + 16'd1;
                    end
                    if (!ctrl[0]) begin
                        m_state = 0;
                        m_cnt   = '0;
                    end else if (wr && ctrl[1]) begin
                        m_state = 2;
                    end
                end
                default: begin
                    m_cnt = '0;
                    m_psc = '0;
                    if (!ctrl[0]) m_state = 0;
                end
            endcase
        end
    endtask

    function automatic logic [63:0] modelStatus();
        logic [7:0] flags;
        flags = {4'b0000, m_pwm, (m_state == 2), m_sticky, (m_state == 1)};
        return {24'h000000, 8'hA5, m_wcnt, flags, m_cnt[15:8], m_cnt[7:0]};
    endfunction

    // One clock: predict, enqueue, clock the DUT, dequeue and compare
    task automatic applyStimulus();
        exp_t e;
        modelClock();
        e.pwm = m_pwm;
        e.irq = m_sticky & ctrl[4];
        e.st  = modelStatus();
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checkOutput("pwm_out", 64'(pwm_out), 64'(e.pwm));
        checkOutput("irq", 64'(irq), 64'(e.irq));
        checkOutput("status", status_regs, e.st);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    int pat27[5] = '{1, 1, 0, 0, 0};
    int pat30[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst    = 1'b1;
        ena    = 1'b1;
        ctrl   = 8'h00;
        presc  = 8'h00;
        period = 16'h0000;
        duty   = 16'h0000;
        modelReset();
        #1;
        checkOutput("reset_status", status_regs, RESET_STATUS);
        checkOutput("reset_pwm", 64'(pwm_out), 64'd0);
        checkOutput("reset_irq", 64'(irq), 64'd0);
        steps(2);
        rst = 1'b0;
        steps(1);

        // Polarity inversion is visible even while idle
        ctrl = C_INV;
        steps(2);
        ctrl = 8'h00;
        steps(1);

        // PRESC=0 PERIOD=4 DUTY=2: pattern 1,1,0,0,0
        period = 16'd4;
        duty   = 16'd2;
        ctrl   = C_EN;
        applyStimulus();
        checkOutput("p27_first", 64'(pwm_out), 64'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("p27_pattern", 64'(pwm_out), 64'(pat27[i % 5]));
        end
        ctrl = 8'h00;
        steps(2);

        // PRESC=3 PERIOD=1 DUTY=1: counter every 4 cycles, pwm 4 high / 4 low
        presc  = 8'd3;
        period = 16'd1;
        duty   = 16'd1;
        ctrl   = C_EN;
        applyStimulus();
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            checkOutput("p28_pwm", 64'(pwm_out), 64'(((i / 4) % 2) == 0));
            checkOutput("p28_cnt", 64'(status_regs[7:0]), 64'(((i + 1) / 4) % 2));
        end
        ctrl = 8'h00;
        steps(2);

        // One-shot PERIOD=2: three ticks then DONE
        ctrl = C_CLR;
        steps(1);
        presc  = 8'd0;
        period = 16'd2;
        duty   = 16'd1;
        ctrl   = C_EN | C_ONE;
        steps(4);
        checkOutput("p29_flags", 64'(status_regs[23:16]), 64'h06);
        checkOutput("p29_wrapcnt", 64'(status_regs[31:24]), 64'd1);
        checkOutput("p29_pwm", 64'(pwm_out), 64'd0);
        steps(2);
        checkOutput("p29_hold", 64'(status_regs[23:16]), 64'h06);
        ctrl = 8'h00;
        steps(1);
        checkOutput("p29_idle", 64'(status_regs[23:16]), 64'h02);

        // DUTY changed 1->3 mid-period with PERIOD=5
        ctrl = C_CLR;
        steps(1);
        period = 16'd5;
        duty   = 16'd1;
        ctrl   = C_EN;
        applyStimulus();
        for (int i = 0; i < 12; i++) begin
            if (i == 3) duty = 16'd3;
            applyStimulus();
            checkOutput("p30_pwm", 64'(pwm_out), 64'(pat30[i]));
        end
        ctrl = 8'h00;
        steps(1);

        // 300 wraps saturate wrap_cnt; clear beats a coincident wrap
        ctrl = C_CLR;
        steps(1);
        period = 16'd0;
        duty   = 16'd1;
        ctrl   = C_EN | C_IRQ;
        steps(301);
        checkOutput("p31_sat", 64'(status_regs[31:24]), 64'd255);
        checkOutput("p31_irq", 64'(irq), 64'd1);
        ctrl = C_EN | C_IRQ | C_CLR;
        steps(1);
        checkOutput("p31_clr_cnt", 64'(status_regs[31:24]), 64'd0);
        checkOutput("p31_clr_sticky", 64'(status_regs[17]), 64'd0);
        checkOutput("p31_clr_irq", 64'(irq), 64'd0);
        ctrl = 8'h00;
        steps(1);

        // Asynchronous reset in the middle of RUN, then ena freeze
        period = 16'd9;
        duty   = 16'd5;
        ctrl   = C_EN | C_IRQ;
        steps(6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("p32_async_status", status_regs, RESET_STATUS);
        checkOutput("p32_async_pwm", 64'(pwm_out), 64'd0);
        checkOutput("p32_async_irq", 64'(irq), 64'd0);
        steps(1);
        rst = 1'b0;
        steps(5);
        checkOutput("p32_restart_cnt", 64'(status_regs[15:0]), 64'd4);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("p32_freeze_cnt", 64'(status_regs[15:0]), 64'd4);
        end
        ena = 1'b1;
        steps(2);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
